acc_sequencer: RTL and testbench

Fetch/decode/execute sequencer for the 8-bit processor. It fetches instruction bytes from program memory through a req/ack handshake, decodes them, and produces the one-cycle control strobes `jump`, `jumpC`, `sin`, `InA` and `twone` consumed by the accumulator control block. It sits between program memory and the accumulator control, and owns the program counter.

---
 rtl/acc_sequencer.sv | 167 ++++++++++++++++
 tb/tb_acc_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_sequencer.sv
// Fetch/decode/execute sequencer: fetches opcode/argument bytes over req/ack, owns pc,
// and issues one-cycle accumulator-control strobes from registered outputs.
module acc_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [7:0] instr,
  input  logic       mem_ack,
  input  logic       carry,
  output logic       mem_req,
  output logic [7:0] pc,
  output logic [7:0] imm,
  output logic       jump,
  output logic       jumpC,
  output logic       sin,
  output logic       InA,
  output logic       twone,
  output logic       out_we,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_FETCH_ARG,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_IN  = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JC  = 4'h5;
  localparam logic [3:0] OP_OUT = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [3:0] opcode_q, opcode_d;
  logic [7:0] imm_q, imm_d;
  logic       mem_req_q, mem_req_d;
  logic       jump_q, jump_d;
  logic       jumpC_q, jumpC_d;
  logic       sin_q, sin_d;
  logic       InA_q, InA_d;
  logic       twone_q, twone_d;
  logic       out_we_q, out_we_d;
  logic       halted_q, halted_d;
  logic       illegal_q, illegal_d;
  logic       ack;

  // An ack only counts while a request is actually outstanding.
  assign ack = mem_req_q & mem_ack;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    imm_d     = imm_q;
    jump_d    = 1'b0;
    jumpC_d   = 1'b0;
    sin_d     = 1'b0;
    InA_d     = 1'b0;
    twone_d   = 1'b0;
    out_we_d  = 1'b0;
    illegal_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (ack) begin
          opcode_d = instr[7:4];
          pc_d     = pc_q + 8'd1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode_q)
          OP_LDI, OP_JMP, OP_JC: state_d = S_FETCH_ARG;
          OP_HLT:                state_d = S_HALT;
          default:               state_d = S_EXEC;
        endcase
      end
      S_FETCH_ARG: begin
        if (ack) begin
          imm_d   = instr;
          pc_d    = pc_q + 8'd1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (opcode_q == OP_JMP || (opcode_q == OP_JC && carry)) pc_d = imm_q;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered, so they are computed on the way into EXEC.
    if (state_d == S_EXEC) begin
      case (opcode_q)
        4'h0:    ;
        OP_LDI:  InA_d    = 1'b1;
        OP_IN:   sin_d    = 1'b1;
        OP_ADD:  twone_d  = 1'b1;
        OP_JMP:  jump_d   = 1'b1;
        OP_JC:   jumpC_d  = 1'b1;
        OP_OUT:  out_we_d = 1'b1;
        OP_HLT:  ;
        default: illegal_d = 1'b1;
      endcase
    end

    mem_req_d = (state_d == S_FETCH) || (state_d == S_FETCH_ARG);
    halted_d  = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= 8'h00;
      opcode_q  <= 4'h0;
      imm_q     <= 8'h00;
      mem_req_q <= 1'b0;
      jump_q    <= 1'b0;
      jumpC_q   <= 1'b0;
      sin_q     <= 1'b0;
      InA_q     <= 1'b0;
      twone_q   <= 1'b0;
      out_we_q  <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      imm_q     <= imm_d;
      mem_req_q <= mem_req_d;
      jump_q    <= jump_d;
      jumpC_q   <= jumpC_d;
      sin_q     <= sin_d;
      InA_q     <= InA_d;
      twone_q   <= twone_d;
      out_we_q  <= out_we_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  assign mem_req = mem_req_q;
  assign pc      = pc_q;
  assign imm     = imm_q;
  assign jump    = jump_q;
  assign jumpC   = jumpC_q;
  assign sin     = sin_q;
  assign InA     = InA_q;
  assign twone   = twone_q;
  assign out_we  = out_we_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// Bench for acc_sequencer: instruction-level ISA model plus a memory responder with
// random wait states, random carry and stray acks while no request is pending.
module tb_acc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       mem_ack = 1'b0;
  logic       carry = 1'b0;
  logic       mem_req;
  logic [7:0] pc;
  logic [7:0] imm;
  logic       jump, jumpC, sin, InA, twone, out_we, halted, illegal;

  int tests = 0;
  int fails = 0;
  logic [7:0] mem [256];
  int strobe_q[$];

  acc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .mem_ack(mem_ack),
    .carry(carry), .mem_req(mem_req), .pc(pc), .imm(imm), .jump(jump),
    .jumpC(jumpC), .sin(sin), .InA(InA), .twone(twone), .out_we(out_we),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Strobe order: {jump, jumpC, sin, InA, twone, out_we, illegal}
  function automatic logic [6:0] exp_vec(input logic [3:0] op);
    case (op)
      4'h0, 4'hF: return 7'b0000000;
      4'h1: return 7'b0001000;
      4'h2: return 7'b0010000;
      4'h3: return 7'b0000100;
      4'h4: return 7'b1000000;
      4'h5: return 7'b0100000;
      4'h6: return 7'b0000010;
      default: return 7'b0000001;
    endcase
  endfunction

  function automatic logic [6:0] strobes();
    return {jump, jumpC, sin, InA, twone, out_we, illegal};
  endfunction

  task automatic fill_mem(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0; carry = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs the program in mem from pc 0. cmode: 0/1 fixed carry, 2 random carry.
  task automatic run_prog(input int max_cyc, input int wmax, input bit wfixed,
                          input int cmode, input bit expect_halt);
    logic [7:0] m_pc, imm_e, a1, nxt;
    logic [3:0] op;
    logic [6:0] s;
    int phase, seen, req_cnt, cur_wait, op_ack, last_ack, cyc;
    bit two, done, c_exec, jc_now;
    m_pc = 8'h00; imm_e = 8'h00; op = 4'h0; two = 1'b0;
    phase = 0; seen = 0; req_cnt = 0; op_ack = -10; last_ack = -10;
    done = 1'b0; c_exec = 1'b0;
    cur_wait = wfixed ? wmax : $urandom_range(wmax, 0);
    for (cyc = 0; cyc < max_cyc && !done; cyc++) begin
      @(negedge clk);
      s = strobes();
      jc_now = 1'b0;
      if (s != 7'b0) begin
        tests++;
        a1 = m_pc + (two ? 8'd2 : 8'd1);
        if (phase != 2 || s !== exp_vec(op) || pc !== a1 ||
            cyc != op_ack + (two ? 1 : 2) || (two && imm !== imm_e)) begin
          fails++;
          $display("FAIL exec_strobe cyc=%0d: got strobes=%b pc=%h imm=%h dly=%0d, expected strobes=%b pc=%h imm=%h dly=%0d",
                   cyc, s, pc, imm, cyc - op_ack, exp_vec(op), a1, imm_e, two ? 1 : 2);
        end
        seen++;
        strobe_q.push_back(cyc);
        if (op == 4'h5) jc_now = 1'b1;
      end
      if (halted) begin
        tests++;
        a1 = m_pc + 8'd1;
        if (phase != 3 || pc !== a1 || cyc != op_ack + 2) begin
          fails++;
          $display("FAIL halt_entry cyc=%0d: got pc=%h dly=%0d phase=%0d, expected pc=%h dly=2 phase=3",
                   cyc, pc, cyc - op_ack, phase, a1);
        end
        done = 1'b1;
      end
      if (cyc == last_ack + 1) begin
        tests++;
        if (mem_req !== 1'b0) begin
          fails++;
          $display("FAIL req_after_ack cyc=%0d: got mem_req=%b, expected 0", cyc, mem_req);
        end
      end
      if (!mem_req && req_cnt != 0) begin
        tests++; fails++;
        $display("FAIL req_dropped cyc=%0d: got mem_req=0 after %0d cycles, expected 1 until ack", cyc, req_cnt);
        req_cnt = 0;
      end
      if (mem_req) begin
        req_cnt++;
        if (req_cnt > cur_wait) begin
          mem_ack = 1'b1;
          if (phase == 2) begin
            tests++;
            if (seen != ((exp_vec(op) != 7'b0) ? 1 : 0)) begin
              fails++;
              $display("FAIL exec_count op=%h: got %0d strobe cycles, expected %0d",
                       op, seen, (exp_vec(op) != 7'b0) ? 1 : 0);
            end
            case (op)
              4'h4:    nxt = imm_e;
              4'h5:    nxt = c_exec ? imm_e : m_pc + 8'd2;
              default: nxt = m_pc + (two ? 8'd2 : 8'd1);
            endcase
            m_pc = nxt;
            phase = 0;
          end
          if (phase == 0) begin
            tests++;
            if (pc !== m_pc) begin
              fails++;
              $display("FAIL fetch_pc cyc=%0d: got pc=%h, expected %h", cyc, pc, m_pc);
            end
            op = mem[m_pc][7:4];
            a1 = m_pc + 8'd1;
            imm_e = mem[a1];
            two = (op == 4'h1 || op == 4'h4 || op == 4'h5);
            phase = two ? 1 : ((op == 4'hF) ? 3 : 2);
            seen = 0;
            op_ack = cyc;
          end else if (phase == 1) begin
            tests++;
            a1 = m_pc + 8'd1;
            if (pc !== a1) begin
              fails++;
              $display("FAIL arg_pc cyc=%0d: got pc=%h, expected %h", cyc, pc, a1);
            end
            phase = 2;
            op_ack = cyc;
          end else begin
            tests++; fails++;
            $display("FAIL fetch_after_halt cyc=%0d: got fetch at pc=%h, expected none", cyc, pc);
          end
          instr = mem[pc];
          last_ack = cyc;
          req_cnt = 0;
          cur_wait = wfixed ? wmax : $urandom_range(wmax, 0);
        end else begin
          mem_ack = 1'b0;
          instr = 8'($urandom);
        end
      end else begin
        mem_ack = 1'($urandom_range(1, 0));
        instr = 8'($urandom);
      end
      carry = (cmode == 2) ? 1'($urandom_range(1, 0)) : 1'(cmode);
      if (jc_now) c_exec = carry;
      run = (cyc == 0);
    end
    mem_ack = 1'b0;
    run = 1'b0;
    if (expect_halt) begin
      tests++;
      if (!done) begin
        fails++;
        $display("FAIL halt_timeout: got halted=%b after %0d cycles, expected 1", halted, max_cyc);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    tests++;
    if ({mem_req, pc, imm, strobes(), halted} !== 24'h0) begin
      fails++;
      $display("FAIL reset_outputs: got req=%b pc=%h imm=%h strb=%b halted=%b, expected all 0",
               mem_req, pc, imm, strobes(), halted);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_ack = 1'($urandom_range(1, 0));
      tests++;
      if (mem_req !== 1'b0 || strobes() !== 7'b0 || pc !== 8'h00) begin
        fails++;
        $display("FAIL idle_quiet: got req=%b strb=%b pc=%h, expected 0 0 00", mem_req, strobes(), pc);
      end
    end
    mem_ack = 1'b0;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    tests++;
    if (mem_req !== 1'b1 || pc !== 8'h00) begin
      fails++;
      $display("FAIL run_start: got req=%b pc=%h, expected 1 00", mem_req, pc);
    end
    do_reset();
  endtask

  task automatic test_straight_line();
    fill_mem(8'hF0);
    mem[0] = 8'h20; mem[1] = 8'h30; mem[2] = 8'h60; mem[3] = 8'hF0;
    strobe_q.delete();
    do_reset();
    run_prog(60, 0, 1'b1, 2, 1'b1);
    tests++;
    if (strobe_q.size() != 3 || strobe_q[1] - strobe_q[0] != 3 || strobe_q[2] - strobe_q[1] != 3) begin
      fails++;
      $display("FAIL strobe_spacing: got %0d strobes, expected 3 strobes 3 cycles apart", strobe_q.size());
    end
    tests++;
    if (halted !== 1'b1 || pc !== 8'h04) begin
      fails++;
      $display("FAIL halt_pc: got halted=%b pc=%h, expected 1 04", halted, pc);
    end
    run = 1'b1;
    repeat (3) @(negedge clk);
    run = 1'b0;
    tests++;
    if (halted !== 1'b1 || mem_req !== 1'b0 || pc !== 8'h04) begin
      fails++;
      $display("FAIL halt_sticky: got halted=%b req=%b pc=%h, expected 1 0 04", halted, mem_req, pc);
    end
  endtask

  task automatic test_two_byte();
    fill_mem(8'hF0);
    mem[0] = 8'h10; mem[1] = 8'hA5; mem[2] = 8'h40; mem[3] = 8'h80;
    strobe_q.delete();
    do_reset();
    run_prog(60, 0, 1'b1, 2, 1'b1);
    tests++;
    if (strobe_q.size() != 2 || pc !== 8'h81 || imm !== 8'h80) begin
      fails++;
      $display("FAIL two_byte: got %0d strobes pc=%h imm=%h, expected 2 81 80", strobe_q.size(), pc, imm);
    end
  endtask

  task automatic test_jc();
    for (int c = 0; c < 3; c++) begin
      fill_mem(8'hF0);
      mem[0] = 8'h50; mem[1] = 8'h33;
      do_reset();
      run_prog(60, 1, 1'b0, c, 1'b1);
      if (c < 2) begin
        tests++;
        if (pc !== ((c == 1) ? 8'h34 : 8'h03)) begin
          fails++;
          $display("FAIL jc_target carry=%0d: got pc=%h, expected %h", c, pc, (c == 1) ? 8'h34 : 8'h03);
        end
      end
    end
  endtask

  task automatic test_wait_states();
    fill_mem(8'hF0);
    mem[0] = 8'h30; mem[1] = 8'h10; mem[2] = 8'h5C;
    do_reset();
    run_prog(80, 3, 1'b1, 2, 1'b1);
    tests++;
    if (imm !== 8'h5C || pc !== 8'h04) begin
      fails++;
      $display("FAIL wait_result: got imm=%h pc=%h, expected 5c 04", imm, pc);
    end
  endtask

  task automatic test_wrap_illegal();
    fill_mem(8'hF0);
    mem[0] = 8'h40; mem[1] = 8'hFE; mem[8'hFE] = 8'h9A; mem[8'hFF] = 8'h07;
    do_reset();
    run_prog(30, 0, 1'b1, 2, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] = 8'($urandom);
        if (mem[i][7:4] == 4'hF && $urandom_range(3, 0) != 0) mem[i] = 8'h00;
      end
      do_reset();
      run_prog(500, 2, 1'b0, 2, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    fill_mem(8'hF0);
    do_reset();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mem_req) begin
        found = 1'b1; mem_ack = 1'b1; instr = 8'h10;
      end else @(negedge clk);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mem_req) found = 1'b1;
      else @(negedge clk);
    end
    tests++;
    if (!found || pc !== 8'h01) begin
      fails++;
      $display("FAIL arg_wait: got req=%b pc=%h, expected 1 01", mem_req, pc);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({mem_req, pc, imm, strobes(), halted} !== 24'h0) begin
      fails++;
      $display("FAIL reset_mid: got req=%b pc=%h imm=%h strb=%b halted=%b, expected all 0",
               mem_req, pc, imm, strobes(), halted);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (mem_req !== 1'b0 || strobes() !== 7'b0) begin
        fails++;
        $display("FAIL post_reset_idle: got req=%b strb=%b, expected 0 0", mem_req, strobes());
      end
    end
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_two_byte();
    test_jc();
    test_wait_states();
    test_wrap_illegal();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
